// File: rtl/fifo_pkg.sv
// ------------------------------------------------------------------
// fifo_pkg : width helpers and flag bundle shared by the FIFO files
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

   function automatic int CNT_W(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int PTR_W(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ------------------------------------------------------------------
// fifo_mem : simple dual-port storage, synchronous write, asynchronous read
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [PTR_W(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic [PTR_W(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_flags.sv
// ------------------------------------------------------------------
// sync_fifo_flags : single-clock FIFO with count, threshold flags, sticky errors
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      w_en,
   input  logic [WIDTH-1:0]          data_in,
   input  logic                      r_en,
   output logic [WIDTH-1:0]          data_out,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [CNT_W(DEPTH)-1:0]   count,
   output logic                      overflow,
   output logic                      underflow,
   input  logic                      err_clr
);

   localparam int c_CW = CNT_W(DEPTH);
   localparam int c_PW = PTR_W(DEPTH);

   localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
   localparam logic [c_CW-1:0] c_AFULL     = c_CW'(AFULL_TH);
   localparam logic [c_CW-1:0] c_AEMPTY    = c_CW'(AEMPTY_TH);
   localparam logic [c_PW-1:0] c_LAST_PTR  = c_PW'(DEPTH - 1);

   logic [c_PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0]  count_q, count_d;
   fifo_flags_t      flags_q, flags_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             w_wr_acc;
   logic             w_rd_acc;
   logic [WIDTH-1:0] w_rdata;

   // Acceptance looks only at the current flags: no full-bypass, no empty-bypass.
   assign w_wr_acc = w_en & ~flags_q.full;
   assign w_rd_acc = r_en & ~flags_q.empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (w_wr_acc) begin
         wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_rd_acc) begin
         rd_ptr_d = (rd_ptr_q == c_LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      end

      count_d = count_q + c_CW'(w_wr_acc) - c_CW'(w_rd_acc);

      flags_d.full         = (count_d == c_DEPTH_CNT);
      flags_d.empty        = (count_d == '0);
      flags_d.almost_full  = (count_d >= c_AFULL);
      flags_d.almost_empty = (count_d <= c_AEMPTY);

      // A fresh rejection outranks a simultaneous clear.
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (w_en && flags_q.full) begin
         ovf_d = 1'b1;
      end
      if (r_en && flags_q.empty) begin
         unf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         flags_q  <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         flags_q  <= flags_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (w_wr_acc & rst_n),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (w_rdata)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = w_rdata;
      end else begin : g_reg_read
         logic [WIDTH-1:0] dout_q;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               dout_q <= '0;
            end else if (w_rd_acc) begin
               dout_q <= w_rdata;
            end
         end
         assign data_out = dout_q;
      end
   endgenerate

   assign full         = flags_q.full;
   assign empty        = flags_q.empty;
   assign almost_full  = flags_q.almost_full;
   assign almost_empty = flags_q.almost_empty;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

`default_nettype wire
